// File: rtl/conv2d_mac_engine_if.sv
// Window-in / pixel-out streaming bundle for conv2d_mac_engine.
// The slave modport is the engine's view; master is the surrounding pipeline.
`timescale 1ns/1ps
interface conv2d_mac_engine_if #(
  parameter int DW   = 16,
  parameter int CIN  = 3,
  parameter int COUT = 8,
  parameter int K    = 3
);
  localparam int CHW = (COUT > 1) ? $clog2(COUT) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [CIN*K*K*DW-1:0]     in_window;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DW-1:0]      out_data;
  logic [CHW-1:0]            out_ch;
  logic                      out_last;
  logic                      sat;

  modport master (
    output in_valid, in_window, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last, sat
  );

  modport slave (
    input  in_valid, in_window, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last, sat
  );
endinterface

// File: rtl/conv2d_mac_engine.sv
// Time-multiplexed single-MAC KxK convolution engine producing COUT requantised pixels per window.
// Optional build macro CONV2D_RELU_EN clamps negative saturated results to zero.
`timescale 1ns/1ps
module conv2d_mac_engine #(
  parameter int DW   = 16,
  parameter int WW   = 16,
  parameter int BW   = 32,
  parameter int CIN  = 3,
  parameter int COUT = 8,
  parameter int K    = 3,
  parameter int ACCW = 48,
  parameter int FRAC = 8,
  parameter int WAW  = 16,
  parameter int BAW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv2d_mac_engine_if.slave    bus,
  output logic [WAW-1:0]        w_addr,
  input  logic signed [WW-1:0]  w_data,
  output logic [BAW-1:0]        b_addr,
  input  logic signed [BW-1:0]  b_data
);

  localparam int N   = CIN * K * K;
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int CHW = (COUT > 1) ? $clog2(COUT) : 1;
  localparam int PW  = DW + WW;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, BIAS, ADD, OUT} state_t;

  state_t                 state;
  logic [NW-1:0]          n;
  logic [CHW-1:0]         co;
  logic signed [ACCW-1:0] acc;
  logic                   vld_p1;
  logic [N*DW-1:0]        win_q;
  logic signed [DW-1:0]   x_p1;

  logic signed [PW-1:0]   prod_p1;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_bias;
  logic signed [ACCW-1:0] r_round;
  logic signed [DW-1:0]   q_sat;
  logic                   q_clip;
  logic                   last_ch;

  function automatic logic signed [ACCW-1:0] round_half_up(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] half;
    half = '0;
    half[FRAC-1] = 1'b1;
    return (a + half) >>> FRAC;
  endfunction

  function automatic logic is_clipped(input logic signed [ACCW-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [ACCW-1:0] r);
    if (r > SAT_MAX) return SAT_MAX[DW-1:0];
    if (r < SAT_MIN) return SAT_MIN[DW-1:0];
    return r[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] q);
`ifdef CONV2D_RELU_EN
    return q[DW-1] ? '0 : q;
`else
    return q;
`endif
  endfunction

  // p1: window element registered one cycle behind its weight address, matching ROM latency
  assign prod_p1  = PW'(x_p1) * PW'(w_data);
  assign prod_ext = ACCW'(prod_p1);
  assign acc_bias = acc + ACCW'(b_data);
  assign r_round  = round_half_up(acc_bias);
  assign q_sat    = relu(saturate(r_round));
  assign q_clip   = is_clipped(r_round);
  assign last_ch  = (co == CHW'(COUT - 1));

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) win_q <= bus.in_window;
    x_p1 <= win_q[int'(n)*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      n             <= '0;
      co            <= '0;
      acc           <= '0;
      vld_p1        <= 1'b0;
      w_addr        <= '0;
      b_addr        <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_last  <= 1'b0;
      bus.sat       <= 1'b0;
    end else begin
      vld_p1 <= (state == MAC);
      if (vld_p1) acc <= acc + prod_ext;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state        <= MAC;
            co           <= '0;
            n            <= '0;
            acc          <= '0;
            w_addr       <= '0;
            bus.in_ready <= 1'b0;
          end
        end

        MAC: begin
          if (n == NW'(N - 1)) begin
            state  <= BIAS;
            b_addr <= BAW'(co);
          end else begin
            n      <= n + NW'(1);
            w_addr <= w_addr + WAW'(1);
          end
        end

        BIAS: state <= ADD;

        // p2: bias folded in and requantised straight into the held output registers
        ADD: begin
          acc           <= acc_bias;
          bus.out_data  <= q_sat;
          bus.sat       <= q_clip;
          bus.out_ch    <= co;
          bus.out_last  <= last_ch;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (last_ch) begin
              state        <= IDLE;
              bus.in_ready <= 1'b1;
            end else begin
              co     <= co + CHW'(1);
              n      <= '0;
              acc    <= '0;
              w_addr <= w_addr + WAW'(1);
              state  <= MAC;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_mac_engine.sv
// Directed table-driven bench for conv2d_mac_engine with behavioural 1-cycle weight/bias ROMs.
`timescale 1ns/1ps
module tb_conv2d_mac_engine;
  localparam int DW = 16, WW = 16, BW = 32, CIN = 3, COUT = 8, K = 3;
  localparam int N = CIN * K * K, WAW = 16, BAW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WAW-1:0]        w_addr;
  logic signed [WW-1:0]  w_data;
  logic [BAW-1:0]        b_addr;
  logic signed [BW-1:0]  b_data;

  logic signed [WW-1:0] wrom [0:(1<<WAW)-1];
  logic signed [BW-1:0] brom [0:(1<<BAW)-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int mode;          // 0: uniform sample s, weight w[co]; 1: ramp samples, one-hot weight at n==co
    int s;
    int w[COUT];
    int b[COUT];
    int e[COUT];
    int es[COUT];
  } vec_t;
  vec_t vec [8];

  conv2d_mac_engine_if #(.DW(DW), .CIN(CIN), .COUT(COUT), .K(K)) bus ();

  conv2d_mac_engine dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .w_addr (w_addr),
    .w_data (w_data),
    .b_addr (b_addr),
    .b_data (b_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int model(input int vi, input int co);
    int e;
    e = vec[vi].e[co];
`ifdef CONV2D_RELU_EN
    if (e < 0) e = 0;
`endif
    return e;
  endfunction

  task automatic load_vec(input int vi);
    for (int i = 0; i < N; i++)
      bus.in_window[i*DW +: DW] = DW'((vec[vi].mode == 0) ? vec[vi].s : i + 1);
    for (int c = 0; c < COUT; c++) begin
      for (int i = 0; i < N; i++)
        wrom[c*N + i] = WW'((vec[vi].mode == 0) ? vec[vi].w[c] : ((i == c) ? 256 : 0));
      brom[c] = vec[vi].b[c];
    end
  endtask

  task automatic run_window(input int vi, input int stall_ch, input bit chk_timing);
    int a, k, held_d;
    load_vec(vi);
    bus.in_valid = 1'b1;
    chk($sformatf("v%0d in_ready_idle", vi), int'(bus.in_ready), 1);
    @(posedge clk); #1;
    a = cyc;
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d in_ready_busy", vi), int'(bus.in_ready), 0);
    for (int co = 0; co < COUT; co++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!bus.out_valid && k < 200);
      if (!bus.out_valid) begin
        chk($sformatf("v%0d ch%0d timeout", vi, co), 0, 1);
        return;
      end
      if (chk_timing && co == 0)        chk($sformatf("v%0d lat_ch0", vi), cyc - a, 29);
      if (chk_timing && co == COUT - 1) chk($sformatf("v%0d lat_last", vi), cyc - a, 239);
      chk($sformatf("v%0d ch%0d out_ch", vi, co), int'(bus.out_ch), co);
      chk($sformatf("v%0d ch%0d out_data", vi, co), int'(bus.out_data), model(vi, co));
      chk($sformatf("v%0d ch%0d sat", vi, co), int'(bus.sat), vec[vi].es[co]);
      chk($sformatf("v%0d ch%0d out_last", vi, co), int'(bus.out_last), (co == COUT - 1) ? 1 : 0);
      if (co == stall_ch) begin
        bus.out_ready = 1'b0;
        held_d = int'(bus.out_data);
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1;
          chk("stall out_valid", int'(bus.out_valid), 1);
          chk("stall out_data", int'(bus.out_data), held_d);
          chk("stall out_ch", int'(bus.out_ch), co);
          chk("stall in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d end in_ready", vi), int'(bus.in_ready), 1);
    chk($sformatf("v%0d end out_valid", vi), int'(bus.out_valid), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready"}, int'(bus.in_ready), 1);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " out_data"}, int'(bus.out_data), 0);
    chk({tag, " out_ch"}, int'(bus.out_ch), 0);
    chk({tag, " out_last"}, int'(bus.out_last), 0);
    chk({tag, " sat"}, int'(bus.sat), 0);
    chk({tag, " w_addr"}, int'(w_addr), 0);
    chk({tag, " b_addr"}, int'(b_addr), 0);
  endtask

  initial begin
    int seen;
    vec[0].mode = 0; vec[0].s = 256;
    vec[0].w = '{default: 256}; vec[0].b = '{default: 0};
    vec[0].e = '{default: 6912}; vec[0].es = '{default: 0};

    vec[1].mode = 0; vec[1].s = 256; vec[1].w = '{default: 0};
    vec[1].b  = '{128, -129, 127, -128, 384, -384, 8388480, 8388479};
    vec[1].e  = '{1, -1, 0, 0, 2, -1, 32767, 32767};
    vec[1].es = '{0, 0, 0, 0, 0, 0, 1, 0};

    vec[2].mode = 0; vec[2].s = 32767;
    vec[2].w = '{default: 32767}; vec[2].b = '{default: 0};
    vec[2].e = '{default: 32767}; vec[2].es = '{default: 1};

    vec[3].mode = 0; vec[3].s = 32767;
    vec[3].w = '{default: -32767}; vec[3].b = '{default: 0};
    vec[3].e = '{default: -32768}; vec[3].es = '{default: 1};

    vec[4].mode = 0; vec[4].s = 0; vec[4].w = '{default: 0};
    vec[4].b  = '{-8388736, -8388737, 0, 0, 0, 0, 0, 0};
    vec[4].e  = '{-32768, -32768, 0, 0, 0, 0, 0, 0};
    vec[4].es = '{0, 1, 0, 0, 0, 0, 0, 0};

    vec[5].mode = 0; vec[5].s = -256;
    vec[5].w = '{default: 512}; vec[5].b = '{default: 0};
    vec[5].e = '{default: -13824}; vec[5].es = '{default: 0};

    vec[6].mode = 0; vec[6].s = 256;
    vec[6].w = '{1, 2, 3, 4, 5, 6, 7, 8}; vec[6].b = '{default: 0};
    vec[6].e = '{27, 54, 81, 108, 135, 162, 189, 216}; vec[6].es = '{default: 0};

    vec[7].mode = 1; vec[7].s = 0;
    vec[7].w = '{default: 0}; vec[7].b = '{default: 0};
    vec[7].e = '{1, 2, 3, 4, 5, 6, 7, 8}; vec[7].es = '{default: 0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_window = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int vi = 0; vi < 8; vi++) run_window(vi, -1, 1'b1);

    run_window(0, 3, 1'b0);

    // abort a window in the middle of channel 2's MAC phase
    load_vec(0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("post_rst no_output", seen, 0);
    chk("post_rst in_ready", int'(bus.in_ready), 1);
    run_window(0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2d_mac_engine.md
Name: conv2d_mac_engine

Overview:
Parametrised, time-multiplexed single-MAC engine that computes one output pixel for COUT filters from a single KxK window of CIN channels.
- Weights and biases are fetched from external synchronous ROMs with 1-cycle read latency.
- Adds valid/ready handshakes on both sides, round-and-saturate requantisation, and per-channel streamed outputs.
- Sits between the line-buffer/window generator and the next CNN layer in the super-resolution pipeline.

Parameters:
DW, 16, signed input/output sample width
WW, 16, signed weight width
BW, 32, signed bias width (same scale as the product, i.e. Q(2*FRAC))
CIN, 3, input channels
COUT, 8, output channels (filters)
K, 3, kernel size (KxK)
ACCW, 48, accumulator width
FRAC, 8, fractional bits of samples and weights
WAW, 16, weight ROM address width
BAW, 8, bias ROM address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  window valid
in_ready  output  1  engine idle, window accepted when in_valid && in_ready
in_window  input  CIN*K*K*DW  packed window; element n=ci*K*K+ky*K+kx at bits [n*DW +: DW]
w_addr  output  WAW  weight ROM address
w_data  input  WW  weight ROM data, valid the cycle after w_addr
b_addr  output  BAW  bias ROM address
b_data  input  BW  bias ROM data, valid the cycle after b_addr
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_data  output  DW  requantised result
out_ch  output  clog2(COUT)  output channel index of out_data
out_last  output  1  high with channel COUT-1
sat  output  1  current out_data was clipped

Behaviour:
- Reset values: all outputs 0 except in_ready=1; FSM in IDLE; accumulator and counters 0.
- Reset asserted mid-operation aborts the window with no partial output.
- IDLE: in_ready=1.
  - On accept: latch in_window, set co=0, n=0, go to MAC.
  - in_valid while not IDLE is ignored (in_ready=0).
- MAC: lasts N=CIN*K*K cycles.
  - Each cycle: w_addr=co*N+n.
  - When n>0, acc += sext(window[n-1])*w_data.
  - After n=N-1, go to BIAS.
  - Window element for product n-1 comes from a registered copy aligned with ROM latency.
- BIAS:
  - Accumulate the last product.
  - Set b_addr=co, go to ADD.
  - acc is cleared at entry to MAC for each channel.
- ADD: acc += sext(b_data); go to OUT.
- OUT requantisation:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round-half-up).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - sat=1 if clipped.
- OUT handshake:
  - out_valid=1, out_ch=co, out_last=(co==COUT-1).
  - out_data, out_ch, sat held stable until out_ready.
  - On handshake: if co==COUT-1, go to IDLE (out_valid drops next cycle); else co+1, go to MAC.
- Per-channel latency: N+3 cycles minimum. Window total: 1+COUT*(N+3) cycles with out_ready held high.
- Stalls: out_ready low freezes the FSM in OUT; w_addr/b_addr hold their last values.
- Widths: products are DW+WW bits, sign-extended to ACCW. ACCW must be >= DW+WW+clog2(N)+1; no internal overflow is permitted.
- Addresses wrap modulo 2^WAW / 2^BAW; sizing the ROMs correctly is the integrator's responsibility.

Optional Feature:
CONV2D_RELU_EN
- Defined: after saturation, negative results are forced to 0. sat still reflects the clip to the DW range only.
- Undefined: signed saturated result passed unchanged.

Test Plan:
1. Defaults; all window samples 256, all weights 256, bias 0 -> 8 outputs of 6912, out_ch 0..7, out_last only on ch7, sat=0; 1+8*30=241 cycles with out_ready=1.
2. Weights 0; bias ch0=128, ch1=-129, ch2=127 -> out_data 1, -1, 0 (rounding check).
3. Samples 32767, weights 32767 -> 32767 with sat=1; same with weights -32767 -> -32768 with sat=1.
4. out_ready low for 10 cycles at ch3 -> out_data/out_ch stable, in_ready=0, no channel skipped or duplicated; resumes with ch4.
5. Reset asserted in MAC of ch2 -> outputs return to reset values, in_ready=1 after release; next window (test 1 data) gives 6912 on all channels.
6. CONV2D_RELU_EN defined; test 3 negative case -> out_data 0, sat=1; test 1 -> unchanged 6912.
